// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: shared mode constants and per-cycle step decode for the counter bank
package counter_bank_pkg;
  localparam bit CNT_WRAP = 1'b1;
  localparam bit CNT_SAT = 1'b0;
  typedef enum logic [2:0] {HOLD, UP, DOWN, LOAD, CLR} step_e;
endpackage

// File: rtl/counter_chan.sv
// counter_chan: one up/down counter channel with clear, load, wrap or saturate, and terminal-count pulse
module counter_chan
  import counter_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit WRAP = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] cnt,
  output logic             eq,
  output logic             tc
);
  step_e step;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic tc_q, tc_d;
  logic at_top, at_bot;
  always_comb begin
    step = clr ? CLR : ld ? LOAD : (inc & ~dec) ? UP : (dec & ~inc) ? DOWN : HOLD;
    at_top = cnt_q >= max_val;
    at_bot = cnt_q == '0;
    cnt_d = cnt_q;
    tc_d = 1'b0;
    unique case (step)
      CLR:  cnt_d = '0;
      LOAD: cnt_d = ld_val;
      UP: begin
        cnt_d = at_top ? (WRAP ? '0 : cnt_q) : cnt_q + 1'b1;
        tc_d = at_top;
      end
      DOWN: begin
        cnt_d = at_bot ? (WRAP ? max_val : cnt_q) : cnt_q - 1'b1;
        tc_d = at_bot;
      end
      default: cnt_d = cnt_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q <= tc_d;
    end
  end
  assign cnt = cnt_q;
  assign tc = tc_q;
  assign eq = cnt_q == max_val;
endmodule

// File: rtl/counter_bank.sv
// counter_bank: NCH independent up/down counters packed onto flat buses
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int NCH = 4,
  parameter int WIDTH = 8,
  parameter bit WRAP = CNT_WRAP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       clr,
  input  logic [NCH-1:0]       ld,
  input  logic [NCH*WIDTH-1:0] ld_val,
  input  logic [NCH-1:0]       inc,
  input  logic [NCH-1:0]       dec,
  input  logic [NCH*WIDTH-1:0] max_val,
  output logic [NCH*WIDTH-1:0] cnt,
  output logic [NCH-1:0]       eq,
  output logic [NCH-1:0]       tc
);
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    counter_chan #(.WIDTH(WIDTH), .WRAP(WRAP)) u_chan (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr[i]),
      .ld     (ld[i]),
      .ld_val (ld_val[i*WIDTH +: WIDTH]),
      .inc    (inc[i]),
      .dec    (dec[i]),
      .max_val(max_val[i*WIDTH +: WIDTH]),
      .cnt    (cnt[i*WIDTH +: WIDTH]),
      .eq     (eq[i]),
      .tc     (tc[i])
    );
  end
endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: checks a wrapping and a saturating bank against an integer model every cycle
module tb_counter_bank;
  localparam int NCH = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0] clr, ld, inc, dec;
  logic [NCH*W-1:0] ld_val, max_val;
  logic [NCH*W-1:0] cnt_w, cnt_s;
  logic [NCH-1:0] eq_w, eq_s, tc_w, tc_s;
  int vecs = 0;
  int errs = 0;
  bit started = 0;
  int m_cnt[2][NCH];
  bit m_tc[2][NCH];

  always #5 clk = ~clk;

  counter_bank #(.NCH(NCH), .WIDTH(W), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_val), .inc(inc), .dec(dec),
    .max_val(max_val), .cnt(cnt_w), .eq(eq_w), .tc(tc_w)
  );
  counter_bank #(.NCH(NCH), .WIDTH(W), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_val), .inc(inc), .dec(dec),
    .max_val(max_val), .cnt(cnt_s), .eq(eq_s), .tc(tc_s)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dcnt(input int m, input int i);
    return m == 0 ? 32'(cnt_w[i*W +: W]) : 32'(cnt_s[i*W +: W]);
  endfunction
  function automatic logic [31:0] dtc(input int m, input int i);
    return m == 0 ? 32'(tc_w[i]) : 32'(tc_s[i]);
  endfunction
  function automatic logic [31:0] deq(input int m, input int i);
    return m == 0 ? 32'(eq_w[i]) : 32'(eq_s[i]);
  endfunction
  function automatic int mx(input int i);
    return int'(max_val[i*W +: W]);
  endfunction

  // model: index 0 is the wrapping bank, 1 the saturating bank
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < NCH; i++) begin
        int c;
        bit t;
        c = m_cnt[m][i];
        t = 0;
        if (rst || clr[i]) c = 0;
        else if (ld[i]) c = int'(ld_val[i*W +: W]);
        else if (inc[i] && !dec[i]) begin
          if (c >= mx(i)) begin t = 1; if (m == 0) c = 0; end
          else c = c + 1;
        end else if (dec[i] && !inc[i]) begin
          if (c == 0) begin t = 1; if (m == 0) c = mx(i); end
          else c = c - 1;
        end
        m_cnt[m][i] = c;
        m_tc[m][i] = t;
      end
  end

  always @(negedge clk) begin
    if (started)
      for (int m = 0; m < 2; m++)
        for (int i = 0; i < NCH; i++) begin
          chk($sformatf("model cnt m%0d ch%0d", m, i), dcnt(m, i), 32'(m_cnt[m][i]));
          chk($sformatf("model tc m%0d ch%0d", m, i), dtc(m, i), 32'(m_tc[m][i]));
          chk($sformatf("model eq m%0d ch%0d", m, i), deq(m, i), 32'(m_cnt[m][i] == mx(i)));
        end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic idle();
    clr = '0; ld = '0; inc = '0; dec = '0;
  endtask

  initial begin
    int ec[7];
    int et[7];
    int sc[5];
    int st[5];
    ec = '{1, 2, 3, 4, 5, 0, 1};
    et = '{0, 0, 0, 0, 0, 1, 0};
    sc = '{1, 2, 3, 3, 3};
    st = '{0, 0, 0, 1, 1};
    rst = 1'b1;
    clr = NCH'($urandom); ld = NCH'($urandom); inc = NCH'($urandom); dec = NCH'($urandom);
    ld_val = {$urandom};
    for (int i = 0; i < NCH; i++) max_val[i*W +: W] = W'($urandom_range(1, 255));
    max_val[2*W +: W] = '0;
    tick(1);
    started = 1;
    tick(1);
    chk("reset cnt_w", 32'(cnt_w), 0);
    chk("reset cnt_s", 32'(cnt_s), 0);
    chk("reset tc_w", 32'(tc_w), 0);
    chk("reset eq_w", 32'(eq_w), 32'b0100);
    rst = 1'b0;
    idle();
    ld_val = '0;
    for (int i = 0; i < NCH; i++) max_val[i*W +: W] = 8'd100;
    max_val[0 +: W] = 8'd5;
    tick(1);
    inc = 4'b0001;
    for (int k = 0; k < 7; k++) begin
      tick(1);
      chk($sformatf("wrap up cnt step %0d", k), 32'(cnt_w[0 +: W]), 32'(ec[k]));
      chk($sformatf("wrap up tc step %0d", k), 32'(tc_w[0]), 32'(et[k]));
    end
    idle(); clr = 4'b0001; tick(1); idle();
    max_val[0 +: W] = 8'd3;
    inc = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk($sformatf("sat cnt step %0d", k), 32'(cnt_s[0 +: W]), 32'(sc[k]));
      chk($sformatf("sat tc step %0d", k), 32'(tc_s[0]), 32'(st[k]));
    end
    idle(); clr = 4'b0001; tick(1); idle();
    max_val[0 +: W] = 8'd9;
    dec = 4'b0001;
    tick(1);
    chk("down wrap cnt", 32'(cnt_w[0 +: W]), 9);
    chk("down wrap tc", 32'(tc_w[0]), 1);
    chk("down sat cnt", 32'(cnt_s[0 +: W]), 0);
    chk("down sat tc", 32'(tc_s[0]), 1);
    idle();
    clr = 4'b0001; ld = 4'b0001; inc = 4'b0001; ld_val[0 +: W] = 8'h2A;
    tick(1);
    chk("prio clr", 32'(cnt_w[0 +: W]), 0);
    clr = '0;
    tick(1);
    chk("prio ld", 32'(cnt_w[0 +: W]), 32'h2A);
    ld = '0; dec = 4'b0001;
    tick(1);
    chk("prio hold cnt", 32'(cnt_w[0 +: W]), 32'h2A);
    chk("prio hold tc", 32'(tc_w[0]), 0);
    idle();
    ld = 4'b1110;
    ld_val = {8'd33, 8'd22, 8'd11, 8'd0};
    tick(1);
    idle();
    ld = 4'b0001; ld_val[0 +: W] = 8'd200; max_val[0 +: W] = 8'd100;
    tick(1);
    idle(); inc = 4'b0001;
    tick(1);
    chk("above max wrap cnt", 32'(cnt_w[0 +: W]), 0);
    chk("above max wrap tc", 32'(tc_w[0]), 1);
    chk("above max sat cnt", 32'(cnt_s[0 +: W]), 200);
    chk("above max sat tc", 32'(tc_s[0]), 1);
    chk("isolation ch1..3", 32'(cnt_w[W +: 3*W]), {8'd0, 8'd33, 8'd22, 8'd11});
    idle();
    for (int k = 0; k < 80; k++) begin
      rst = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NCH; i++) begin
        clr[i] = ($urandom_range(0, 11) == 0);
        ld[i] = ($urandom_range(0, 7) == 0);
        inc[i] = $urandom_range(0, 1) == 1;
        dec[i] = $urandom_range(0, 2) == 0;
        ld_val[i*W +: W] = W'($urandom_range(0, 8));
        max_val[i*W +: W] = W'($urandom_range(0, 6));
      end
      tick(1);
    end
    rst = 1'b0;
    idle();
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
